// File: rtl/aldffe_pkg.sv
// Shared constants and helpers for the aldffe_shreg shift register.
// Build option: define ALDFFE_SHREG_ASYNC_LOAD_EN for an asynchronous, level-sensitive aload.
package aldffe_pkg;

    // Legal parameter ranges for the shift register
    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 64;
    localparam int unsigned DEPTH_MIN = 1;
    localparam int unsigned DEPTH_MAX = 16;

    // Ceiling log2, clamped to at least one bit so a count port is never zero-width
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage : aldffe_pkg

// File: rtl/aldffe_stage.sv
// One shift-register stage: data plus valid flag with enable, sync reset and load.
// Build option: ALDFFE_SHREG_ASYNC_LOAD_EN selects an asynchronous, level-sensitive load.
module aldffe_stage
    import aldffe_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_aload,
    input  logic [WIDTH-1:0] i_ad,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_d_valid,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

`ifdef ALDFFE_SHREG_ASYNC_LOAD_EN
    // Load captured asynchronously; held afterwards until clocked updates resume
    always_ff @(posedge clk or posedge i_aload) begin
        if (i_aload) begin
            r_data  <= i_ad;
            r_valid <= 1'b1;
        end else if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_data  <= i_d;
            r_valid <= i_d_valid;
        end
    end

    // Transparent load path so the stage follows ad for as long as aload is high
    assign o_q       = i_aload ? i_ad : r_data;
    assign o_q_valid = i_aload | r_valid;
`else
    // Synchronous load with priority aload > rst > en
    always_ff @(posedge clk) begin
        if (i_aload) begin
            r_data  <= i_ad;
            r_valid <= 1'b1;
        end else if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_data  <= i_d;
            r_valid <= i_d_valid;
        end
    end

    assign o_q       = r_data;
    assign o_q_valid = r_valid;
`endif

endmodule : aldffe_stage

// File: rtl/aldffe_shreg.sv
// DEPTH-stage shift register of WIDTH-bit words with valid flags, load and a valid count.
// Build option: ALDFFE_SHREG_ASYNC_LOAD_EN makes aload asynchronous and level-sensitive.
module aldffe_shreg
    import aldffe_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         d,
    input  logic                     d_valid,
    input  logic                     aload,
    input  logic [WIDTH-1:0]         ad,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic [DEPTH*WIDTH-1:0]   taps,
    output logic [clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] w_data  [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic [CW-1:0]    r_count;

    // Stage chain: stage 0 takes the input word, stage i takes stage i-1
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] w_in_d;
        logic             w_in_valid;

        if (i == 0) begin : g_head
            assign w_in_d     = d;
            assign w_in_valid = d_valid;
        end else begin : g_body
            assign w_in_d     = w_data[i-1];
            assign w_in_valid = w_valid[i-1];
        end

        aldffe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .i_en      (en),
            .i_aload   (aload),
            .i_ad      (ad),
            .i_d       (w_in_d),
            .i_d_valid (w_in_valid),
            .o_q       (w_data[i]),
            .o_q_valid (w_valid[i])
        );

        assign taps[i*WIDTH +: WIDTH] = w_data[i];
    end

    assign q       = w_data[DEPTH-1];
    assign q_valid = w_valid[DEPTH-1];

`ifdef ALDFFE_SHREG_ASYNC_LOAD_EN
    // Valid population count tracked incrementally: +1 for a valid word in, -1 for one dropped
    always_ff @(posedge clk or posedge aload) begin
        if (aload) begin
            r_count <= CW'(DEPTH);
        end else if (rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + CW'(d_valid) - CW'(w_valid[DEPTH-1]);
        end
    end

    assign count = aload ? CW'(DEPTH) : r_count;
`else
    // Valid population count tracked incrementally: +1 for a valid word in, -1 for one dropped
    always_ff @(posedge clk) begin
        if (aload) begin
            r_count <= CW'(DEPTH);
        end else if (rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + CW'(d_valid) - CW'(w_valid[DEPTH-1]);
        end
    end

    assign count = r_count;
`endif

endmodule : aldffe_shreg

// File: tb/tb_aldffe_shreg.sv
// Directed self-checking bench for aldffe_shreg with WIDTH=4, DEPTH=3.
module tb_aldffe_shreg;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CW    = 2;

    logic                   clk;
    logic                   rst;
    logic                   en;
    logic [WIDTH-1:0]       d;
    logic                   d_valid;
    logic                   aload;
    logic [WIDTH-1:0]       ad;
    logic [WIDTH-1:0]       q;
    logic                   q_valid;
    logic [DEPTH*WIDTH-1:0] taps;
    logic [CW-1:0]          count;

    int checks;
    int errors;

    aldffe_shreg #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .d       (d),
        .d_valid (d_valid),
        .aload   (aload),
        .ad      (ad),
        .q       (q),
        .q_valid (q_valid),
        .taps    (taps),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        en      = 1'b0;
        d       = '0;
        d_valid = 1'b0;
        aload   = 1'b0;
        ad      = '0;

        // Reset for one edge
        step();
        check("rst_q",       64'(q),       64'h0);
        check("rst_q_valid", 64'(q_valid), 64'h0);
        check("rst_count",   64'(count),   64'h0);
        check("rst_taps",    64'(taps),    64'h0);

        // Shift in 1,2,3 with valid
        rst = 1'b0; en = 1'b1; d_valid = 1'b1; d = 4'h1;
        step();
        check("fill1_count",   64'(count),   64'h1);
        check("fill1_q_valid", 64'(q_valid), 64'h0);
        check("fill1_taps",    64'(taps),    64'h001);
        d = 4'h2;
        step();
        check("fill2_taps",    64'(taps),    64'h012);
        d = 4'h3;
        step();
        check("fill3_q",       64'(q),       64'h1);
        check("fill3_q_valid", 64'(q_valid), 64'h1);
        check("fill3_taps",    64'(taps),    64'h123);
        check("fill3_count",   64'(count),   64'h3);

        // Hold with en=0 while d toggles
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d       = WIDTH'(4'hF - i);
            d_valid = i[0];
            step();
            check("hold_taps",  64'(taps),  64'h123);
            check("hold_count", 64'(count), 64'h3);
        end

        // Drain one slot so the load visibly changes count: s0=7 (invalid)
        en = 1'b1; d = 4'h7; d_valid = 1'b0;
        step();
        check("pre_load_taps",  64'(taps),  64'h237);
        check("pre_load_count", 64'(count), 64'h2);
        en = 1'b0;

        // Load pulse placed between edges
        ad = 4'hA; aload = 1'b1;
        #2;
`ifdef ALDFFE_SHREG_ASYNC_LOAD_EN
        check("aload_async_taps",  64'(taps),  64'hAAA);
        check("aload_async_count", 64'(count), 64'h3);
`else
        check("aload_sync_taps_before",  64'(taps),  64'h237);
        check("aload_sync_count_before", 64'(count), 64'h2);
`endif
        step();
        aload = 1'b0;
        #1;
        check("aload_taps_after",  64'(taps),  64'hAAA);
        check("aload_count_after", 64'(count), 64'h3);
        check("aload_q_valid",     64'(q_valid), 64'h1);

        // Drain with invalid words from full: count 3 -> 2 -> 1 -> 0
        en = 1'b1; d = 4'h5; d_valid = 1'b0;
        step();
        check("drain1_count", 64'(count), 64'h2);
        check("drain1_q",     64'(q),     64'hA);
        step();
        check("drain2_count", 64'(count), 64'h1);
        step();
        check("drain3_count",   64'(count),   64'h0);
        check("drain3_q_valid", 64'(q_valid), 64'h0);
        check("drain3_taps",    64'(taps),    64'h555);

        // aload wins over rst and en
        aload = 1'b1; rst = 1'b1; en = 1'b1; d = 4'h9; d_valid = 1'b1;
        step();
        check("prio_load_taps",  64'(taps),  64'hAAA);
        check("prio_load_count", 64'(count), 64'h3);

        // rst wins over en after aload falls
        aload = 1'b0;
        step();
        check("prio_rst_taps",    64'(taps),    64'h000);
        check("prio_rst_count",   64'(count),   64'h0);
        check("prio_rst_q_valid", 64'(q_valid), 64'h0);

        // Shifting resumes once rst is released
        rst = 1'b0;
        step();
        check("resume_taps",  64'(taps),  64'h009);
        check("resume_count", 64'(count), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_aldffe_shreg
